// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
// Contents:
//   DATA_W     - width of one FIFO word / UART data field
//   PAR_*      - encodings of the PARITY parameter
//   tx_state_e - transmitter FSM states
package fifo_uart_pkg;

  localparam int DATA_W   = 8;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Bus between the FIFO read side / TX pin and the UART transmitter.
// Signals:
//   tx_enable  - permits new frames to start
//   fifo_data  - FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty - FIFO empty flag
//   fifo_rd_en - one-cycle read pulse per byte
//   tx         - serial line, idle high
//   busy       - transmitter owns a byte (POP through STOP)
//   frame_done - pulse on the last STOP cycle
// Modports: master = FIFO/system side, slave = transmitter.
interface fifo_uart_tx_if;
  import fifo_uart_pkg::*;

  logic              tx_enable;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic              tx;
  logic              busy;
  logic              frame_done;

  modport master (
    output tx_enable, fifo_data, fifo_empty,
    input  fifo_rd_en, tx, busy, frame_done
  );

  modport slave (
    input  tx_enable, fifo_data, fifo_empty,
    output fifo_rd_en, tx, busy, frame_done
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and wraps; o_tick marks the last cycle of each
// serial bit. i_clear holds the counter at 0 so the first bit after a clear
// lasts a full period.
// Ports:
//   clk     - system clock
//   reset   - synchronous active-low reset
//   i_clear - synchronous clear
//   o_tick  - high on the last cycle of a bit period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = w_last && !i_clear;

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage that serialises each popped byte as a UART frame:
// start bit, 8 data bits LSB-first, optional parity bit, 1 or 2 stop bits.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-low reset
//   bus   - fifo_uart_tx_if.slave (tx_enable, fifo_data, fifo_empty in;
//           fifo_rd_en, tx, busy, frame_done out)
// All outputs are decoded from registered state only, so there is no
// combinational path from any input to fifo_rd_en or tx.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           reset,
  fifo_uart_tx_if.slave  bus
);

  if (CLKS_PER_BIT < 2 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
    $error("fifo_uart_tx: illegal CLKS_PER_BIT/PARITY/STOP_BITS combination");
  end

  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic       PAR_INV   = (PARITY == PAR_ODD);

  tx_state_e         r_state;
  tx_state_e         w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic [2:0]        r_bit_idx;
  logic              w_tick;
  logic              w_baud_clr;
  logic              w_last_stop;
  logic              w_tx;
  logic              w_rd_en;
  logic              w_busy;
  logic              w_frame_done;

  // The bit timer only runs while a bit is on the line.
  assign w_baud_clr  = (r_state == ST_IDLE) || (r_state == ST_POP) || (r_state == ST_WAIT);
  // In STOP the bit index counts stop bits (it wrapped to 0 at the end of DATA).
  assign w_last_stop = (r_bit_idx == STOP_LAST);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_baud_clr),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Byte capture in WAIT: the registered FIFO presents data one cycle after
  // the POP pulse. Parity is computed here because the shift register is
  // consumed bit by bit afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_bit_idx <= '0;
    end else if (r_state == ST_WAIT) begin
      r_shift   <= bus.fifo_data;
      r_par     <= (^bus.fifo_data) ^ PAR_INV;
      r_bit_idx <= '0;
    end else if (w_tick) begin
      if (r_state == ST_DATA) begin
        r_shift   <= r_shift >> 1;
        r_bit_idx <= r_bit_idx + 3'd1;
      end else if (r_state == ST_STOP) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tx         = 1'b1;
    w_rd_en      = 1'b0;
    w_busy       = 1'b1;
    w_frame_done = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (bus.tx_enable && !bus.fifo_empty) w_state_nxt = ST_POP;
      end
      ST_POP: begin
        w_rd_en     = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_state_nxt = ST_START;
      end
      ST_START: begin
        w_tx = 1'b0;
        if (w_tick) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        w_tx = r_shift[0];
        if (w_tick && (r_bit_idx == 3'd7)) begin
          w_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        w_tx = r_par;
        if (w_tick) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_tick && w_last_stop) begin
          w_frame_done = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.tx         = w_tx;
  assign bus.fifo_rd_en = w_rd_en;
  assign bus.busy       = w_busy;
  assign bus.frame_done = w_frame_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx. Three instances with CLKS_PER_BIT=4:
// index 0 without parity, 1 even parity, 2 odd parity. Each has a small
// registered-read FIFO model in front of it.
module tb_fifo_uart_tx;

  logic        clk;
  logic        reset;
  logic [2:0]  en;
  logic [2:0]  tx_s;
  logic [2:0]  rd_s;
  logic [2:0]  busy_s;
  logic [2:0]  done_s;
  logic [7:0]  mem [3][16];
  int          wr_ptr [3];
  int          rd_cnt [3];
  int          checks;
  int          failures;
  int          n;

  fifo_uart_tx_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_inst
    int rd_ptr = 0;

    fifo_uart_tx #(
      .CLKS_PER_BIT (4),
      .PARITY       (g),
      .STOP_BITS    (1)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus[g])
    );

    always @(posedge clk) begin
      if (bus[g].fifo_rd_en === 1'b1) begin
        bus[g].fifo_data <= mem[g][rd_ptr[3:0]];
        rd_ptr           <= rd_ptr + 1;
      end
    end

    assign bus[g].tx_enable  = en[g];
    assign bus[g].fifo_empty = (wr_ptr[g] == rd_ptr);
    assign tx_s[g]   = bus[g].tx;
    assign rd_s[g]   = bus[g].fifo_rd_en;
    assign busy_s[g] = bus[g].busy;
    assign done_s[g] = bus[g].frame_done;
    assign rd_cnt[g] = rd_ptr;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int g, input logic [7:0] b);
    mem[g][wr_ptr[g] % 16] = b;
    wr_ptr[g] = wr_ptr[g] + 1;
  endtask

  // Waits (bounded) for the POP pulse, then checks WAIT and every cycle of
  // the frame against the LSB-first bit vector, then the first IDLE cycle.
  // n returns how many cycles passed before the POP pulse was seen.
  task automatic frame(input int g, input logic [11:0] bits, input int nbits,
                       input int drop_bit, output int nw);
    nw = 0;
    while (rd_s[g] !== 1'b1 && nw < 200) begin
      @(negedge clk);
      nw++;
    end
    chk($sformatf("rd_pulse[%0d]", g), 32'(rd_s[g]), 32'd1);
    @(negedge clk);
    chk($sformatf("rd_single[%0d]", g), 32'(rd_s[g]), 32'd0);
    chk($sformatf("wait_tx[%0d]", g), 32'(tx_s[g]), 32'd1);
    chk($sformatf("wait_busy[%0d]", g), 32'(busy_s[g]), 32'd1);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (b == drop_bit && c == 0) en[g] = 1'b0;
        chk($sformatf("tx[%0d] bit%0d cyc%0d", g, b, c), 32'(tx_s[g]), 32'(bits[b]));
        chk($sformatf("done[%0d] bit%0d cyc%0d", g, b, c), 32'(done_s[g]),
            32'((b == nbits - 1) && (c == 3)));
        chk($sformatf("busy[%0d] bit%0d", g, b), 32'(busy_s[g]), 32'd1);
        chk($sformatf("rd_in_frame[%0d]", g), 32'(rd_s[g]), 32'd0);
      end
    end
    @(negedge clk);
    chk($sformatf("idle_tx[%0d]", g), 32'(tx_s[g]), 32'd1);
    chk($sformatf("idle_busy[%0d]", g), 32'(busy_s[g]), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    en       = 3'b001;
    wr_ptr   = '{0, 0, 0};
    push(0, 8'h01);

    // Reset held 3 cycles with a non-empty FIFO and enable high.
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx_s[0]), 32'd1);
      chk("rst_rd", 32'(rd_s[0]), 32'd0);
      chk("rst_busy", 32'(busy_s[0]), 32'd0);
      chk("rst_done", 32'(done_s[0]), 32'd0);
    end
    reset = 1'b1;

    // Single byte 0x01: 0,1,0,0,0,0,0,0,0,1
    frame(0, 12'b001000000010, 10, -1, n);
    chk("single_latency", 32'(n), 32'd1);
    chk("single_pops", 32'(rd_cnt[0]), 32'd1);

    // Back-to-back 0x09 then 0x07; n==1 on the second means a 3-cycle gap.
    push(0, 8'h09);
    push(0, 8'h07);
    frame(0, 12'b001000010010, 10, -1, n);
    frame(0, 12'b001000001110, 10, -1, n);
    chk("b2b_gap", 32'(n), 32'd1);
    chk("b2b_pops", 32'(rd_cnt[0]), 32'd3);

    // Empty FIFO with enable high: nothing happens.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("empty_rd", 32'(rd_s[0]), 32'd0);
      chk("empty_tx", 32'(tx_s[0]), 32'd1);
    end

    // Enable dropped in DATA bit 2 of 0x55: frame completes, 0x0A stays queued.
    push(0, 8'h55);
    push(0, 8'h0A);
    frame(0, 12'b001010101010, 10, 3, n);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("disabled_rd", 32'(rd_s[0]), 32'd0);
    end
    chk("disabled_pops", 32'(rd_cnt[0]), 32'd4);

    // Reset during DATA bit 3 of 0x0A; afterwards 0x0B is sent, not 0x0A.
    push(0, 8'h0B);
    en[0] = 1'b1;
    n = 0;
    while (rd_s[0] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_pop", 32'(rd_s[0]), 32'd1);
    repeat (17) @(negedge clk);
    chk("rst_mid_bit2", 32'(tx_s[0]), 32'd0);
    @(negedge clk);
    chk("rst_mid_bit3", 32'(tx_s[0]), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_tx", 32'(tx_s[0]), 32'd1);
    chk("rst_mid_busy", 32'(busy_s[0]), 32'd0);
    chk("rst_mid_rd", 32'(rd_s[0]), 32'd0);
    reset = 1'b1;
    frame(0, 12'b001000010110, 10, -1, n);
    chk("rst_resume_latency", 32'(n), 32'd1);
    chk("rst_resume_pops", 32'(rd_cnt[0]), 32'd6);
    en[0] = 1'b0;

    // Even parity on 0x07: parity bit 1, 11 bits.
    push(1, 8'h07);
    en[1] = 1'b1;
    frame(1, 12'b011000001110, 11, -1, n);
    en[1] = 1'b0;

    // Odd parity on 0x07: parity bit 0, 11 bits.
    push(2, 8'h07);
    en[2] = 1'b1;
    frame(2, 12'b010000001110, 11, -1, n);
    en[2] = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
